// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with debounce.
// Ports: CLK/RESET (sync, active-high), row_in[3:0] (async, active-low),
// col_out[3:0] (one-cold column drive), key_pulse (1-cycle per press),
// key_value[3:0] (last accepted key code), key_held (press to release).
module keypad_scanner #(
    parameter int SCAN_DIV     = 24_000,
    parameter int DEBOUNCE_CNT = 480_000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       key_pulse,
    output logic [3:0] key_value,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CNT);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DB_LAST    = BW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {
        SCAN       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    sync1_q;
    logic [3:0]    row_s_q;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [BW-1:0] db_q, db_d;
    logic [1:0]    col_q, col_d;
    logic [3:0]    pat_q, pat_d;
    logic          key_pulse_q, key_pulse_d;
    logic [3:0]    key_value_q, key_value_d;
    logic          key_held_q, key_held_d;

    logic [3:0] row_low;
    logic       one_low;
    logic       all_high;
    logic       sample_pt;
    logic       pat_match;
    logic       press_done;
    logic       release_done;

    // Row pattern is one-cold while debouncing; decode it with the
    // frozen column into the keypad legend code.
    function automatic logic [3:0] key_code(input logic [3:0] pat,
                                            input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] v;
        case (pat)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        case ({r, col})
            4'h0:    v = 4'h1;
            4'h1:    v = 4'h2;
            4'h2:    v = 4'h3;
            4'h3:    v = 4'hA;
            4'h4:    v = 4'h4;
            4'h5:    v = 4'h5;
            4'h6:    v = 4'h6;
            4'h7:    v = 4'hB;
            4'h8:    v = 4'h7;
            4'h9:    v = 4'h8;
            4'hA:    v = 4'h9;
            4'hB:    v = 4'hC;
            4'hC:    v = 4'hE;
            4'hD:    v = 4'h0;
            4'hE:    v = 4'hF;
            default: v = 4'hD;
        endcase
        return v;
    endfunction

    assign row_low   = ~row_s_q;
    // Exactly one row low: non-zero and a power of two.
    assign one_low   = (row_low != 4'b0000)
                    && ((row_low & (row_low - 4'd1)) == 4'b0000);
    assign all_high  = (row_s_q == 4'hF);
    assign sample_pt = (dwell_q == DWELL_LAST);
    assign pat_match = (row_s_q == pat_q);

    assign press_done   = (state_q == PRESS_DB) && pat_match
                       && (db_q == DB_LAST);
    assign release_done = (state_q == RELEASE_DB) && all_high
                       && (db_q == DB_LAST);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= SCAN;
            sync1_q     <= 4'hF;
            row_s_q     <= 4'hF;
            dwell_q     <= '0;
            db_q        <= '0;
            col_q       <= 2'd0;
            pat_q       <= 4'hF;
            key_pulse_q <= 1'b0;
            key_value_q <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= row_in;
            row_s_q     <= sync1_q;
            dwell_q     <= dwell_d;
            db_q        <= db_d;
            col_q       <= col_d;
            pat_q       <= pat_d;
            key_pulse_q <= key_pulse_d;
            key_value_q <= key_value_d;
            key_held_q  <= key_held_d;
        end
    end

    // Next-state: column, dwell and debounce counters follow the state.
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        db_d    = db_q;
        col_d   = col_q;
        pat_d   = pat_q;
        unique case (state_q)
            SCAN: begin
                if (!sample_pt) begin
                    dwell_d = dwell_q + 1'b1;
                end else if (one_low) begin
                    state_d = PRESS_DB;
                    pat_d   = row_s_q;
                    db_d    = '0;
                    dwell_d = '0;
                end else begin
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end
            end
            PRESS_DB: begin
                if (!pat_match) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = HELD;
                    db_d    = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                if (all_high) begin
                    state_d = RELEASE_DB;
                    db_d    = '0;
                end
            end
            RELEASE_DB: begin
                if (!all_high) begin
                    state_d = HELD;
                    db_d    = '0;
                end else if (db_q == DB_LAST) begin
                    state_d = SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    db_d    = '0;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_comb begin
        key_pulse_d = 1'b0;
        key_value_d = key_value_q;
        key_held_d  = key_held_q;
        if (press_done) begin
            key_pulse_d = 1'b1;
            key_value_d = key_code(pat_q, col_q);
            key_held_d  = 1'b1;
        end
        if (release_done) begin
            key_held_d = 1'b0;
        end
    end

    assign col_out   = ~(4'b0001 << col_q);
    assign key_pulse = key_pulse_q;
    assign key_value = key_value_q;
    assign key_held  = key_held_q;

endmodule
